audio_mix_engine: RTL and testbench

Parametrised successor to the fixed 8-channel audio output path. Each frame it walks N channels over a fetch handshake, applies per-channel left and right volume, and accumulates into wide left and right sums. It saturates the sums and streams them as I²S, with bclk and lrclk generated from the system clock. It sits between the per-channel sample units and the audio DAC pins.

---
 rtl/audio_mix_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_audio_mix_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_engine.sv
// Audio mix engine: walks the channels each frame, applies left/right volume into wide sums,
// saturates them and streams the previous frame's mix out as Philips I2S.
//
// state | meaning
// IDLE  | out of reset, nothing scheduled until the first frame start
// SCAN  | look at the enable of channel ch_q
// REQ   | fetch_req held for ch_q until fetch_ack
// MAC   | accumulate the captured sample with ch_q volumes
// DONE  | mix complete, waiting for the next frame start

module audio_mix_engine #(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_W     = 16,
  parameter int VOL_W        = 8,
  parameter int BCLK_DIV     = 12,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic                cfg_enable,
  input  logic [VOL_W-1:0]    cfg_vol_l,
  input  logic [VOL_W-1:0]    cfg_vol_r,
  output logic                fetch_req,
  output logic [CH_W-1:0]     fetch_channel,
  input  logic                fetch_ack,
  input  logic [SAMPLE_W-1:0] fetch_sample,
  output logic                frame_start,
  input  logic                status_clr,
  output logic                clip_l,
  output logic                clip_r,
  output logic                underrun,
  output logic                audio_bclk,
  output logic                audio_lrclk,
  output logic                audio_dout
);

  localparam int SLOTS  = 2 * SAMPLE_W;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int DIV_W  = $clog2(BCLK_DIV);
  localparam int ACC_W  = SAMPLE_W + VOL_W + CH_W + 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_MAC, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [ACC_W-1:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                  clip_l_q, clip_l_d, clip_r_q, clip_r_d, underrun_q, underrun_d;
  logic                  clip_l_set, clip_r_set, underrun_set;

  logic [DIV_W-1:0]      div_q, div_d;
  logic                  bclk_q, bclk_d, dout_q, dout_d, frame_start_q;
  logic [SLOT_W-1:0]     slot_q, slot_d, dout_idx;
  logic                  bclk_tick, bclk_fall, frame_tick;
  logic [SLOTS-1:0]      frame_word;

  logic [NUM_CHANNELS-1:0] en_q;
  logic [VOL_W-1:0]        vol_l_q [NUM_CHANNELS];
  logic [VOL_W-1:0]        vol_r_q [NUM_CHANNELS];
  logic                    cfg_ok, ch_last;

  logic signed [PROD_W-1:0] prod_l, prod_r, shr_l, shr_r;
  logic [ACC_W-1:0]         term_l, term_r;
  logic [SAMPLE_W:0]        sat_l, sat_r;

  generate
    if (NUM_CHANNELS == (1 << CH_W)) begin : g_full_range
      assign cfg_ok = 1'b1;
    end else begin : g_part_range
      assign cfg_ok = (int'(cfg_channel) < NUM_CHANNELS);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        vol_l_q[i] <= '0;
        vol_r_q[i] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      en_q[cfg_channel]    <= cfg_enable;
      vol_l_q[cfg_channel] <= cfg_vol_l;
      vol_r_q[cfg_channel] <= cfg_vol_r;
    end
  end

  // bclk falls on a terminal count while high; the fall that wraps the slot counter starts a frame
  assign bclk_tick  = (div_q == '0);
  assign bclk_fall  = bclk_tick & bclk_q;
  assign frame_tick = bclk_fall & (slot_q == SLOT_W'(SLOTS - 1));
  assign frame_word = {hold_l_q, hold_r_q};

  always_comb begin
    div_d    = bclk_tick ? DIV_W'(BCLK_DIV - 1) : div_q - DIV_W'(1);
    bclk_d   = bclk_tick ? ~bclk_q : bclk_q;
    slot_d   = slot_q;
    dout_d   = dout_q;
    dout_idx = '0;
    if (bclk_fall) begin
      slot_d   = frame_tick ? '0 : slot_q + SLOT_W'(1);
      // one-slot delay: slot 0 still carries the old R LSB (word bit 0)
      dout_idx = frame_tick ? '0 : SLOT_W'(SLOTS - 1) - slot_q;
      dout_d   = frame_word[dout_idx];
    end
  end

  function automatic logic [SAMPLE_W:0] saturate(input logic [ACC_W-1:0] a);
    logic [ACC_W-SAMPLE_W:0] upper;
    upper = a[ACC_W-1:SAMPLE_W-1];
    if ((&upper) || !(|upper)) saturate = {1'b0, a[SAMPLE_W-1:0]};
    else if (a[ACC_W-1])       saturate = {2'b11, {(SAMPLE_W-1){1'b0}}};
    else                       saturate = {2'b10, {(SAMPLE_W-1){1'b1}}};
  endfunction

  assign sat_l = saturate(acc_l_q);
  assign sat_r = saturate(acc_r_q);

  assign prod_l = $signed({{(VOL_W+1){sample_q[SAMPLE_W-1]}}, sample_q}) *
                  $signed({{(SAMPLE_W+1){1'b0}}, vol_l_q[ch_q]});
  assign prod_r = $signed({{(VOL_W+1){sample_q[SAMPLE_W-1]}}, sample_q}) *
                  $signed({{(SAMPLE_W+1){1'b0}}, vol_r_q[ch_q]});
  assign shr_l  = prod_l >>> (VOL_W - 1);
  assign shr_r  = prod_r >>> (VOL_W - 1);
  assign term_l = {{(ACC_W-PROD_W){shr_l[PROD_W-1]}}, shr_l};
  assign term_r = {{(ACC_W-PROD_W){shr_r[PROD_W-1]}}, shr_r};
  assign ch_last = (ch_q == CH_W'(NUM_CHANNELS - 1));

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    sample_d     = sample_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    clip_l_set   = 1'b0;
    clip_r_set   = 1'b0;
    underrun_set = 1'b0;
    if (frame_tick) begin
      if (state_q == S_DONE) begin
        hold_l_d   = sat_l[SAMPLE_W-1:0];
        hold_r_d   = sat_r[SAMPLE_W-1:0];
        clip_l_set = sat_l[SAMPLE_W];
        clip_r_set = sat_r[SAMPLE_W];
      end else if (state_q != S_IDLE) begin
        // IDLE never had a mix scheduled, so only a started mix can under-run
        underrun_set = 1'b1;
      end
      acc_l_d = '0;
      acc_r_d = '0;
      ch_d    = '0;
      state_d = S_SCAN;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (en_q[ch_q])   state_d = S_REQ;
          else if (ch_last) state_d = S_DONE;
          else              ch_d    = ch_q + CH_W'(1);
        end
        S_REQ: begin
          if (fetch_ack) begin
            sample_d = fetch_sample;
            state_d  = S_MAC;
          end
        end
        S_MAC: begin
          acc_l_d = acc_l_q + term_l;
          acc_r_d = acc_r_q + term_r;
          if (ch_last) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_SCAN;
          end
        end
        default: ;
      endcase
    end
  end

  assign clip_l_d   = clip_l_set   | (clip_l_q   & ~status_clr);
  assign clip_r_d   = clip_r_set   | (clip_r_q   & ~status_clr);
  assign underrun_d = underrun_set | (underrun_q & ~status_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      sample_q      <= '0;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      clip_l_q      <= 1'b0;
      clip_r_q      <= 1'b0;
      underrun_q    <= 1'b0;
      div_q         <= DIV_W'(BCLK_DIV - 1);
      bclk_q        <= 1'b0;
      slot_q        <= '0;
      dout_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      sample_q      <= sample_d;
      acc_l_q       <= acc_l_d;
      acc_r_q       <= acc_r_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      clip_l_q      <= clip_l_d;
      clip_r_q      <= clip_r_d;
      underrun_q    <= underrun_d;
      div_q         <= div_d;
      bclk_q        <= bclk_d;
      slot_q        <= slot_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_tick;
    end
  end

  assign fetch_req     = (state_q == S_REQ);
  assign fetch_channel = ch_q;
  assign frame_start   = frame_start_q;
  assign clip_l        = clip_l_q;
  assign clip_r        = clip_r_q;
  assign underrun      = underrun_q;
  assign audio_bclk    = bclk_q;
  assign audio_lrclk   = (slot_q >= SLOT_W'(SAMPLE_W));
  assign audio_dout    = dout_q;

endmodule

// File: tb/tb_audio_mix_engine.sv
// Directed bench for audio_mix_engine: per-scenario tasks with hand-computed I2S words and flags.
module tb_audio_mix_engine;
  localparam int N   = 8;
  localparam int SW  = 16;
  localparam int DIV = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_channel = '0;
  logic        cfg_enable = 1'b0;
  logic [7:0]  cfg_vol_l = '0, cfg_vol_r = '0;
  logic        fetch_req;
  logic [2:0]  fetch_channel;
  logic        fetch_ack;
  logic [15:0] fetch_sample;
  logic        frame_start;
  logic        status_clr = 1'b0;
  logic        clip_l, clip_r, underrun;
  logic        audio_bclk, audio_lrclk, audio_dout;

  int vectors = 0, miscompares = 0;
  logic [15:0] samples [N];
  bit   stall_en = 0;
  int   stall_ch = 0;
  int   req_count = 0, last_ch = -1, req_unstable = 0;
  logic req_prev = 1'b0;
  int   cyc = 0;

  audio_mix_engine #(.NUM_CHANNELS(N), .SAMPLE_W(SW), .VOL_W(8), .BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_enable(cfg_enable),
    .cfg_vol_l(cfg_vol_l), .cfg_vol_r(cfg_vol_r), .fetch_req(fetch_req), .fetch_channel(fetch_channel),
    .fetch_ack(fetch_ack), .fetch_sample(fetch_sample), .frame_start(frame_start),
    .status_clr(status_clr), .clip_l(clip_l), .clip_r(clip_r), .underrun(underrun),
    .audio_bclk(audio_bclk), .audio_lrclk(audio_lrclk), .audio_dout(audio_dout));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // sample source: acks any request unless that channel is being stalled
  initial begin
    fetch_ack = 1'b0;
    fetch_sample = '0;
    for (int i = 0; i < N; i++) samples[i] = '0;
    forever begin
      @(negedge clk);
      if (fetch_req && !req_prev) begin
        req_count++;
        last_ch = int'(fetch_channel);
      end else if (fetch_req && int'(fetch_channel) != last_ch) begin
        req_unstable++;
      end
      req_prev = fetch_req;
      if (fetch_req && !(stall_en && int'(fetch_channel) == stall_ch)) begin
        fetch_ack = 1'b1;
        fetch_sample = samples[fetch_channel];
      end else begin
        fetch_ack = 1'b0;
      end
    end
  end

  task automatic wait_fs(input string tag);
    bit seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1;
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL %s_frame_start: got no pulse in 1000 clks, required one", tag);
    end
  endtask

  task automatic wait_bclk(input logic lvl, output int t);
    bit seen = 0;
    t = cyc;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (audio_bclk === lvl) begin seen = 1; t = cyc; end
    end
    if (!seen) begin
      vectors++; miscompares++;
      $display("FAIL bclk_level: got no bclk=%0b in 100 clks, required toggle", lvl);
    end
  endtask

  // starts pre clks after a frame_start sample point, samples mid-slot for slots 0..31 and next slot 0
  task automatic capture(input int pre, output logic [31:0] word, output logic [31:0] lrpat);
    word = '0;
    lrpat = '0;
    repeat (pre) @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      lrpat[k] = audio_lrclk;
      if (k > 0) word[32-k] = audio_dout;
      repeat (2*DIV) @(negedge clk);
    end
    word[0] = audio_dout;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
  endtask

  task automatic cfg_ch(input int ch, input bit en, input logic [7:0] vl, input logic [7:0] vr);
    @(negedge clk);
    cfg_we = 1'b1; cfg_channel = 3'(ch); cfg_enable = en; cfg_vol_l = vl; cfg_vol_r = vr;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input logic [7:0] mask, input logic [7:0] vl, input logic [7:0] vr);
    for (int i = 0; i < N; i++) cfg_ch(i, mask[i], vl, vr);
  endtask

  // mix runs in the frame after config, its result streams in the frame after that
  task automatic mix_frame(input string tag, output logic [31:0] word);
    logic [31:0] lr;
    wait_fs(tag);
    pulse_clr();
    wait_fs(tag);
    capture(12, word, lr);
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {fetch_req, frame_start, clip_l, clip_r, underrun, audio_bclk, audio_lrclk, audio_dout, fetch_channel};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %b, required 0", outs); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if ({fetch_req, audio_bclk} !== 2'b00) begin
      miscompares++; $display("FAIL post_reset_idle: got req/bclk %b, required 00", {fetch_req, audio_bclk});
    end
  endtask

  task automatic test_unity_single();
    logic [31:0] w;
    samples[0] = 16'h1000;
    cfg_all(8'h00, 8'd0, 8'd0);
    cfg_ch(0, 1'b1, 8'd128, 8'd64);
    mix_frame("unity", w);
    vectors++;
    if (w !== 32'h1000_0800) begin miscompares++; $display("FAIL unity_word: got %h, required 10000800", w); end
    vectors++;
    if ({clip_l, clip_r, underrun} !== 3'b000) begin
      miscompares++; $display("FAIL unity_flags: got %b, required 000", {clip_l, clip_r, underrun});
    end
  endtask

  task automatic test_clip();
    logic [31:0] w;
    for (int i = 0; i < N; i++) samples[i] = 16'h7000;
    cfg_all(8'hFF, 8'd128, 8'd128);
    mix_frame("clip", w);
    vectors++;
    if (w !== 32'h7FFF_7FFF) begin miscompares++; $display("FAIL clip_word: got %h, required 7fff7fff", w); end
    vectors++;
    if ({clip_l, clip_r} !== 2'b11) begin miscompares++; $display("FAIL clip_flags: got %b, required 11", {clip_l, clip_r}); end
    pulse_clr();
    vectors++;
    if ({clip_l, clip_r} !== 2'b00) begin miscompares++; $display("FAIL clip_clear: got %b, required 00", {clip_l, clip_r}); end
  endtask

  task automatic test_neg_sat();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) samples[i] = 16'hC000;
    cfg_all(8'h07, 8'd128, 8'd128);
    mix_frame("negsat", w);
    vectors++;
    if (w !== 32'h8000_8000) begin miscompares++; $display("FAIL negsat_word: got %h, required 80008000", w); end
    vectors++;
    if ({clip_l, clip_r} !== 2'b11) begin miscompares++; $display("FAIL negsat_flags: got %b, required 11", {clip_l, clip_r}); end
  endtask

  task automatic test_floor();
    logic [31:0] w;
    samples[0] = 16'hFFFF;
    cfg_all(8'h01, 8'd64, 8'd0);
    mix_frame("floor", w);
    vectors++;
    if (w !== 32'hFFFF_0000) begin miscompares++; $display("FAIL floor_word: got %h, required ffff0000", w); end
    vectors++;
    if ({clip_l, clip_r} !== 2'b00) begin miscompares++; $display("FAIL floor_flags: got %b, required 00", {clip_l, clip_r}); end
  endtask

  task automatic test_vol_max();
    logic [31:0] w;
    samples[0] = 16'h0100;
    cfg_all(8'h01, 8'd255, 8'd128);
    mix_frame("volmax", w);
    vectors++;
    if (w !== 32'h01FE_0100) begin miscompares++; $display("FAIL volmax_word: got %h, required 01fe0100", w); end
  endtask

  task automatic test_underrun();
    logic [31:0] w, lr;
    samples[0] = 16'h0100; samples[1] = 16'h0200; samples[2] = 16'h0300;
    cfg_all(8'h07, 8'd128, 8'd128);
    mix_frame("urun_pre", w);
    vectors++;
    if (w !== 32'h0600_0600 || underrun !== 1'b0) begin
      miscompares++; $display("FAIL urun_pre: got %h/%b, required 06000600/0", w, underrun);
    end
    stall_ch = 2;
    stall_en = 1;
    wait_fs("urun");
    repeat (50) @(negedge clk);
    vectors++;
    if ({fetch_req, fetch_channel} !== {1'b1, 3'd2}) begin
      miscompares++; $display("FAIL urun_stall_req: got req/ch %b/%0d, required 1/2", fetch_req, fetch_channel);
    end
    pulse_clr();
    wait_fs("urun");
    vectors++;
    if (fetch_req !== 1'b0) begin miscompares++; $display("FAIL urun_req_drop: got %b, required 0", fetch_req); end
    @(negedge clk);
    vectors++;
    if ({fetch_req, fetch_channel} !== {1'b1, 3'd0}) begin
      miscompares++; $display("FAIL urun_rescan: got req/ch %b/%0d, required 1/0", fetch_req, fetch_channel);
    end
    stall_en = 0;
    capture(11, w, lr);
    vectors++;
    if (w !== 32'h0600_0600) begin miscompares++; $display("FAIL urun_hold: got %h, required 06000600", w); end
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL urun_flag: got %b, required 1", underrun); end
  endtask

  task automatic test_single_ch5();
    logic [31:0] w, lr;
    samples[5] = 16'h1234;
    cfg_all(8'h20, 8'd128, 8'd128);
    wait_fs("ch5");
    wait_fs("ch5");
    req_count = 0;
    req_unstable = 0;
    wait_fs("ch5");
    vectors++;
    if (req_count !== 1 || last_ch !== 5 || req_unstable !== 0) begin
      miscompares++;
      $display("FAIL ch5_fetches: got count/ch/unstable %0d/%0d/%0d, required 1/5/0", req_count, last_ch, req_unstable);
    end
    capture(12, w, lr);
    vectors++;
    if (w !== 32'h1234_1234) begin miscompares++; $display("FAIL ch5_word: got %h, required 12341234", w); end
  endtask

  task automatic test_timing();
    int t0, t_r1, t_f, t_r2, fs1, fs2;
    logic [31:0] w, lr;
    wait_bclk(1'b0, t0);
    wait_bclk(1'b1, t_r1);
    wait_bclk(1'b0, t_f);
    wait_bclk(1'b1, t_r2);
    vectors++;
    if (t_r2 - t_r1 !== 2*DIV) begin miscompares++; $display("FAIL bclk_period: got %0d, required %0d", t_r2 - t_r1, 2*DIV); end
    vectors++;
    if (t_f - t_r1 !== DIV) begin miscompares++; $display("FAIL bclk_high: got %0d, required %0d", t_f - t_r1, DIV); end
    wait_fs("timing");
    fs1 = cyc;
    wait_fs("timing");
    fs2 = cyc;
    vectors++;
    if (fs2 - fs1 !== 768) begin miscompares++; $display("FAIL frame_period: got %0d, required 768", fs2 - fs1); end
    @(negedge clk);
    vectors++;
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL frame_pulse_width: got %b, required 0", frame_start); end
    capture(11, w, lr);
    vectors++;
    if (lr !== 32'hFFFF_0000) begin miscompares++; $display("FAIL lrclk_slots: got %h, required ffff0000", lr); end
  endtask

  task automatic test_reset_mid_req();
    logic [10:0] outs;
    logic [31:0] w, lr;
    bit seen = 0;
    samples[0] = 16'h1000;
    cfg_all(8'h01, 8'd128, 8'd128);
    stall_ch = 0;
    stall_en = 1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (fetch_req === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rst_wait_req: got no fetch_req in 2000 clks, required one"); end
    #2 rst = 1'b1;
    #1;
    outs = {fetch_req, frame_start, clip_l, clip_r, underrun, audio_bclk, audio_lrclk, audio_dout, fetch_channel};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL rst_async_outputs: got %b, required 0", outs); end
    @(negedge clk);
    stall_en = 0;
    rst = 1'b0;
    cfg_all(8'h01, 8'd128, 8'd128);
    wait_fs("rst_first");
    capture(12, w, lr);
    vectors++;
    if (w !== 32'h0) begin miscompares++; $display("FAIL rst_first_frame: got %h, required 00000000", w); end
    wait_fs("rst_next");
    capture(12, w, lr);
    vectors++;
    if (w !== 32'h1000_1000) begin miscompares++; $display("FAIL rst_recover: got %h, required 10001000", w); end
  endtask

  initial begin
    test_reset();
    test_unity_single();
    test_clip();
    test_neg_sat();
    test_floor();
    test_vol_max();
    test_underrun();
    test_single_ch5();
    test_timing();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
